flight_sequencer: RTL and testbench

Game-level controller that sequences the bird flight-physics datapath. It owns the INIT/READY/PLAY/DEAD game state, divides the system clock into physics frame ticks, and synchronises and edge-detects the flap button. On each tick it issues exactly one physics command: a flap or a gravity step. It sits between the top-level Start/Ack handshake and the physics block, and also drives the physics reset and a pipe-pass score counter.

---
 rtl/flight_sequencer.sv | 115 +++++++++++
 tb/tb_flight_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/flight_sequencer.sv
// Game-state controller for the bird physics: frame ticks, flap button edge,
// one physics command per tick, physics reset and saturating pipe score.
module flight_sequencer #(
    parameter int                 TICK_DIV = 833333,
    parameter logic signed [9:0]  Y_MIN    = 10'sd0,
    parameter logic signed [9:0]  Y_MAX    = 10'sd470
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              Start,
    input  logic              Ack,
    input  logic              Btn,
    input  logic              Collide,
    input  logic              PipePass,
    input  logic signed [9:0] Bird_Y,
    output logic              PhysReset,
    output logic              PhysStep,
    output logic              FlapReq,
    output logic [7:0]        Score,
    output logic              q_Init,
    output logic              q_Ready,
    output logic              q_Play,
    output logic              q_Dead
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        S_INIT  = 4'b0001,
        S_READY = 4'b0010,
        S_PLAY  = 4'b0100,
        S_DEAD  = 4'b1000
    } state_e;

    state_e          state_q, state_d;
    logic            s1_q, s2_q, s3_q;
    logic            s1_d, s2_d, s3_d;
    logic            pend_q, pend_d;
    logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [7:0]      score_q, score_d;

    logic btn_edge;
    logic in_play;
    logic tick;
    logic dead;

    assign btn_edge = s2_q & ~s3_q;
    assign in_play  = (state_q == S_PLAY);
    assign tick     = in_play & (tick_cnt_q == TICK_LAST);
    assign dead     = in_play & (Collide | (Bird_Y < Y_MIN) | (Bird_Y > Y_MAX));

    always_ff @(posedge Clk) begin
        if (reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:  if (Start)    state_d = S_READY;
            S_READY: if (btn_edge) state_d = S_PLAY;
            S_PLAY:  if (dead)     state_d = S_DEAD;
            S_DEAD:  if (Ack)      state_d = S_INIT;
            default:               state_d = S_INIT;
        endcase
    end

    always_comb begin
        PhysReset = (state_q == S_INIT) | (state_q == S_READY);
        FlapReq   = tick & pend_q & ~dead;
        PhysStep  = tick & ~pend_q & ~dead;
        Score     = score_q;
        q_Init    = (state_q == S_INIT);
        q_Ready   = (state_q == S_READY);
        q_Play    = in_play;
        q_Dead    = (state_q == S_DEAD);
    end

    // pend and tick_cnt default to zero so any state exit clears them
    always_comb begin
        s1_d       = Btn;
        s2_d       = s1_q;
        s3_d       = s2_q;
        pend_d     = 1'b0;
        tick_cnt_d = '0;
        score_d    = score_q;
        if (state_q == S_INIT && Start) score_d = 8'd0;
        if (state_q == S_READY && btn_edge) pend_d = 1'b1;
        if (in_play && !dead) begin
            pend_d     = (pend_q & ~FlapReq) | btn_edge;
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
            if (PipePass && score_q != 8'hFF) score_d = score_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            pend_q     <= 1'b0;
            tick_cnt_q <= '0;
            score_q    <= 8'd0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            pend_q     <= pend_d;
            tick_cnt_q <= tick_cnt_d;
            score_q    <= score_d;
        end
    end

endmodule

// File: tb/tb_flight_sequencer.sv
// Directed bench for flight_sequencer with TICK_DIV=4: vector table for the
// main game flow plus hand sequences for death, score, hold and reset cases.
module tb_flight_sequencer;

    logic              Clk = 1'b0;
    logic              reset = 1'b1;
    logic              Start = 1'b0;
    logic              Ack = 1'b0;
    logic              Btn = 1'b0;
    logic              Collide = 1'b0;
    logic              PipePass = 1'b0;
    logic signed [9:0] Bird_Y = 10'sd100;
    logic              PhysReset, PhysStep, FlapReq;
    logic [7:0]        Score;
    logic              q_Init, q_Ready, q_Play, q_Dead;

    int checks = 0;
    int failures = 0;

    flight_sequencer #(.TICK_DIV(4)) dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Btn(Btn),
        .Collide(Collide), .PipePass(PipePass), .Bird_Y(Bird_Y),
        .PhysReset(PhysReset), .PhysStep(PhysStep), .FlapReq(FlapReq),
        .Score(Score), .q_Init(q_Init), .q_Ready(q_Ready),
        .q_Play(q_Play), .q_Dead(q_Dead)
    );

    always #5 Clk = ~Clk;

    localparam logic [3:0] I = 4'b1000, R = 4'b0100, P = 4'b0010, D = 4'b0001;

    typedef struct {
        logic st, ak, bt, co, pp;
        int   by;
        logic [3:0] es;
        logic pr, ps, fr;
        logic [7:0] sc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic st, logic ak, logic bt, logic co,
                                logic pp, int by, logic [3:0] es,
                                logic pr, logic ps, logic fr, logic [7:0] sc);
        vec_t v;
        v.st = st; v.ak = ak; v.bt = bt; v.co = co; v.pp = pp; v.by = by;
        v.es = es; v.pr = pr; v.ps = ps; v.fr = fr; v.sc = sc;
        return v;
    endfunction

    function automatic logic [14:0] obs();
        return {q_Init, q_Ready, q_Play, q_Dead, PhysReset, PhysStep, FlapReq, Score};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // INIT -> READY -> PLAY; leaves PLAY with tick_cnt=0 and pend=1
    task automatic go_play();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        Btn = 1'b1;
        cyc();
        cyc();
        cyc();
        Btn = 1'b0;
        chk("go_play", q_Play, 1'b1);
    endtask

    initial begin
        int flaps, steps, coinc;

        // main flow: st ak bt co pp by | state pr ps fr score
        vq.push_back(mk(1,0,0,0,0,100, I,1,0,0,0));
        vq.push_back(mk(0,0,1,0,0,100, R,1,0,0,0));
        vq.push_back(mk(0,0,1,0,0,100, R,1,0,0,0));
        vq.push_back(mk(0,0,1,0,0,100, R,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0,100, P,0,0,0,0));
        vq.push_back(mk(0,1,0,0,0,100, P,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,1,0));
        vq.push_back(mk(0,0,0,0,0,470, P,0,0,0,0));
        vq.push_back(mk(0,0,0,0,1,470, P,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,470, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,470, P,0,1,0,1));
        vq.push_back(mk(0,0,1,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,1,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,1,0,0,100, P,0,1,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,1,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,1,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,1,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, P,0,0,0,1));
        vq.push_back(mk(0,0,0,0,1,-1,  P,0,0,0,1));
        vq.push_back(mk(0,1,0,0,1,100, D,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,100, I,1,0,0,1));

        do_reset();
        chk("reset_state", obs(), {I, 1'b1, 1'b0, 1'b0, 8'd0});
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("idle%0d", i), obs(), {I, 1'b1, 1'b0, 1'b0, 8'd0});
            cyc();
        end

        for (int i = 0; i < vq.size(); i++) begin
            Start = vq[i].st; Ack = vq[i].ak; Btn = vq[i].bt;
            Collide = vq[i].co; PipePass = vq[i].pp; Bird_Y = 10'(vq[i].by);
            #1;
            chk($sformatf("vec%0d", i), obs(),
                {vq[i].es, vq[i].pr, vq[i].ps, vq[i].fr, vq[i].sc});
            cyc();
        end
        Start = 0; Ack = 0; Btn = 0; Collide = 0; PipePass = 0; Bird_Y = 10'sd100;

        // upper bound exceeded on a flap tick
        go_play();
        cyc(); cyc(); cyc();
        Bird_Y = 10'sd471;
        #1;
        chk("y471_cmd", {PhysStep, FlapReq}, 2'b00);
        cyc();
        chk("y471_dead", {q_Play, q_Dead}, 2'b01);
        Bird_Y = 10'sd100;
        Ack = 1'b1;
        cyc();
        Ack = 1'b0;
        chk("y471_init", {q_Init, PhysReset}, 2'b11);

        // collision on a tick, then Start held through DEAD -> INIT
        go_play();
        cyc(); cyc(); cyc();
        Collide = 1'b1;
        #1;
        chk("coll_cmd", {PhysStep, FlapReq}, 2'b00);
        cyc();
        Collide = 1'b0;
        chk("coll_dead", {q_Dead, PhysReset}, 2'b10);
        Start = 1'b1;
        Ack = 1'b1;
        cyc();
        Ack = 1'b0;
        chk("coll_init", q_Init, 1'b1);
        cyc();
        Start = 1'b0;
        chk("start_held_ready", q_Ready, 1'b1);

        // score saturation and hold through DEAD/INIT
        go_play();
        for (int i = 0; i < 260; i++) begin
            PipePass = 1'b1;
            cyc();
            PipePass = 1'b0;
            cyc();
            if (i == 9) chk("score10", Score, 8'd10);
        end
        chk("score_sat", {q_Play, Score}, {1'b1, 8'd255});
        Collide = 1'b1;
        PipePass = 1'b1;
        cyc();
        Collide = 1'b0;
        for (int i = 0; i < 5; i++) begin
            PipePass = 1'b1;
            cyc();
            PipePass = 1'b0;
            cyc();
        end
        chk("score_dead", {q_Dead, Score}, {1'b1, 8'd255});
        Ack = 1'b1;
        cyc();
        Ack = 1'b0;
        chk("score_init", {q_Init, Score}, {1'b1, 8'd255});
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        chk("score_clear", {q_Ready, Score}, {1'b1, 8'd0});

        // button held 40 cycles from READY: one flap, steps after
        flaps = 0; steps = 0; coinc = 0;
        for (int c = 0; c < 44; c++) begin
            Btn = (c < 40);
            #1;
            if (FlapReq) flaps++;
            if (PhysStep) steps++;
            if (FlapReq && PhysStep) coinc++;
            cyc();
        end
        Btn = 1'b0;
        chk("hold_flaps", flaps, 1);
        chk("hold_steps", steps, 9);
        chk("hold_coinc", coinc, 0);
        chk("hold_play", q_Play, 1'b1);

        // reset in PLAY with pend=1, tick_cnt=2
        do_reset();
        go_play();
        cyc(); cyc();
        chk("pre_rst_state", {dut.pend_q, dut.tick_cnt_q}, {1'b1, 2'd2});
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_state", obs(), {I, 1'b1, 1'b0, 1'b0, 8'd0});
        chk("mid_rst_regs", {dut.pend_q, dut.tick_cnt_q}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
